// File: rtl/bist_host.sv
// BIST start/end handshake initiator with saturating run/fail counters.
// Optional watchdog on WAIT_END enabled by defining BIST_HOST_TIMEOUT_EN.
module bist_host #(
  parameter int START_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             bist_end,
  input  logic             pass_nfail,
  output logic             bist_start,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             timeout,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    WAIT_END,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             result_q, result_d;
  logic             tmo_q, tmo_d;
  logic             bend_q, bend_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             rise;
  logic             expire;

`ifdef BIST_HOST_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WW-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = '0;
    if (state_q == WAIT_END) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign expire = (state_q == WAIT_END) &&
                  (wdog_q == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign expire = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rise = bist_end & ~bend_q;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    start_d  = start_q;
    done_d   = 1'b0;
    result_d = result_q;
    tmo_d    = tmo_q;
    run_d    = run_q;
    fail_d   = fail_q;
    bend_d   = bist_end;
    unique case (state_q)
      IDLE: begin
        hold_d = HW'(START_HOLD - 1);
        if (req) begin
          state_d = ASSERT;
          start_d = 1'b1;
          tmo_d   = 1'b0;
        end
      end
      ASSERT: begin
        if (hold_q == '0) begin
          state_d = WAIT_END;
          start_d = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      WAIT_END: begin
        start_d = 1'b0;
        // A completion edge outranks a coincident watchdog expiry.
        if (rise) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = pass_nfail;
          run_d    = sat_inc(run_q);
          if (!pass_nfail) begin
            fail_d = sat_inc(fail_q);
          end
        end else if (expire) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = 1'b0;
          tmo_d    = 1'b1;
          run_d    = sat_inc(run_q);
          fail_d   = sat_inc(fail_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      tmo_q    <= 1'b0;
      bend_q   <= 1'b0;
      run_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
      bend_q   <= bend_d;
      run_q    <= run_d;
      fail_q   <= fail_d;
    end
  end

  assign bist_start = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign timeout    = tmo_q;
  assign run_count  = run_q;
  assign fail_count = fail_q;

endmodule

// File: doc/bist_host.md
# bist_host

Initiator side of the BIST start/end handshake. Issues a `bist_start` pulse to the BIST top level on request, waits for the rising edge of `bist_end`, and captures `pass_nfail`. Bounds each run with an optional watchdog, and keeps saturating run and failure counters. Sits between the test-access/command logic and the BIST top level, on the same clock.

## Interface
- `START_HOLD`, 2: number of cycles `bist_start` is held high per run; legal range ≥1.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in cycles spent in WAIT_END; legal range ≥1.
- `CNT_W`, 8: width of `run_count` and `fail_count`.

Ports, clock and reset first:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  1: run request; sampled only in IDLE; a level held high issues back-to-back runs.
- `bist_end`  in  1: completion from the BIST top level; only its rising edge is used.
- `pass_nfail`  in  1: result from the BIST top level; 1 means pass.
- `bist_start`  out  1: start strobe to the BIST top level; registered.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a run ends, by completion or timeout.
- `result`  out  1: pass/fail of the last run; held until the next run ends.
- `timeout`  out  1: high when the last run ended by watchdog; cleared when the next run is accepted.
- `run_count`  out  CNT_W: number of runs ended.
- `fail_count`  out  CNT_W: number of runs ended with a fail or a timeout.

## Operation
States: IDLE, ASSERT, WAIT_END, DONE.
- **Reset values:** every output is 0; state is IDLE; the watchdog is 0; the `bist_end` edge register is 0.
- **IDLE:**
  - `req`=1 moves to ASSERT.
  - Clears `timeout`.
  - Loads the hold counter with START_HOLD-1.
- **ASSERT:**
  - `bist_start`=1.
  - The hold counter decrements each cycle.
  - At 0, moves to WAIT_END; `bist_start` goes low on that same edge.
  - A `bist_end` rising edge seen in ASSERT is ignored.
- **WAIT_END:**
  - `bist_start`=0.
  - The watchdog increments each cycle.
  - A `bist_end` rising edge (current=1, previous=0) does the following:
    - `result`<=`pass_nfail` sampled in that cycle.
    - `run_count`++.
    - `fail_count`++ if `pass_nfail`=0.
    - Moves to DONE.
  - A stale high `bist_end` carried over from a previous run is not an edge; the block waits for a fall and then a rise.
- **Watchdog expiry** occurs when the watchdog reaches TIMEOUT_CYCLES-1 with no edge in that cycle. The block then sets `result`<=0 and `timeout`<=1, increments `run_count` and `fail_count`, and moves to DONE.
- **Edge and expiry in the same cycle:** the edge wins, so completion is recorded, not a timeout.
- **DONE:**
  - `done`=1 for exactly this one cycle.
  - Returns to IDLE unconditionally.
  - The next `req` is therefore seen no earlier than the cycle after DONE, which guarantees at least one low cycle of `bist_start` between runs.
- **Counters** saturate at 2^CNT_W-1 and do not wrap.
- **Reset mid-run** returns the block to IDLE on the next edge. `bist_start` drops on that edge, and counters and result are cleared.

## Timing
- Latency:
  - `req` high at edge N gives `bist_start` high from edge N+1 through N+START_HOLD.
  - ASSERT lasts START_HOLD cycles.
  - A `bist_end` edge detected at edge M gives `done`, `result` and counter updates visible after edge M+1.
  - Maximum run length is 1 + START_HOLD + TIMEOUT_CYCLES + 1 cycles.
- `busy` is high from the cycle after `req` is accepted through DONE inclusive.

## Configuration
- With `BIST_HOST_TIMEOUT_EN` defined: the watchdog is present as described above.
- Without it:
  - The watchdog logic is removed.
  - WAIT_END waits indefinitely.
  - `timeout` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.
  - Only `reset` can exit a hung run.

## Test plan
All scenarios use START_HOLD=2, TIMEOUT_CYCLES=16 and CNT_W=4.
- **Single pass run:** `req` pulsed for one cycle, then `bist_end` rises 5 cycles after `bist_start` falls, with `pass_nfail`=1. Expect:
  - `bist_start` high for exactly 2 cycles.
  - `done` pulses once.
  - `result`=1, `run_count`=1, `fail_count`=0.
- **Fail run:** same as above but `pass_nfail`=0. Expect `result`=0, `run_count`=1, `fail_count`=1, `timeout`=0.
- **Timeout:** `bist_end` is never raised (macro defined). Expect:
  - `done` pulses 16 cycles after entering WAIT_END.
  - `timeout`=1, `result`=0, `fail_count`=1.
  - `timeout` clears on the next accepted `req`.
- **Stale `bist_end` and ignored early edge:** `bist_end` is held high from the previous run, and a rise is injected during ASSERT. Expect no completion until a fresh low→high occurs in WAIT_END.
- **Back-to-back and saturation:** `req` held high for 20 passing runs. Expect:
  - `bist_start` is low for ≥1 cycle between runs.
  - `run_count` stops at 15.
- **Reset mid-run:** `reset` asserted in WAIT_END. Expect `bist_start`, `busy`, counters and `result` all 0 after the next edge; the block is back in IDLE.
